// File: rtl/bus_master.sv
// 68000-bus initiator: runs one Monitor read/write cycle on the CPU bus after BR/BG/BGACK arbitration.
// Latency: arbitration + 2-flop sync + SETUP_CYCLES + 2 strobe cycles + slave DTACK delay + negation/release.
// Backpressure: CMD_READY is high only in IDLE; one command in flight, completion signalled by RSP_VALID.
module bus_master #(
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        MCLK_IN,
  input  logic        RESET_IN,
  input  logic        CMD_VALID_IN,
  output logic        CMD_READY,
  input  logic        CMD_WR_IN,
  input  logic [22:0] CMD_ADDR_IN,
  input  logic [15:0] CMD_DATA_IN,
  input  logic        CMD_UDS_IN,
  input  logic        CMD_LDS_IN,
  output logic        RSP_VALID,
  output logic [15:0] RSP_DATA,
  output logic        RSP_BERR,
  output logic        RSP_TIMEOUT,
  input  logic        BG_IN,
  input  logic        BGACK_IN,
  input  logic        AS_IN,
  input  logic        DTACK_IN,
  input  logic        BERR_IN,
  input  logic [15:0] DATA_IN,
  output logic        BR,
  output logic        BGACK,
  output logic        BUS_OE,
  output logic        DATA_OE,
  output logic        AS_OUT,
  output logic        UDS_OUT,
  output logic        LDS_OUT,
  output logic        WR_OUT,
  output logic [22:0] ADDR_OUT,
  output logic [15:0] DATA_OUT
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_SETUP, S_STROBE, S_WRDS, S_WAIT,
    S_LATCH, S_END, S_NEG, S_RELEASE, S_DONE
  } state_t;

  // Last timer value before the bound is reached; the timer restarts at 0 on every state entry.
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_timer;
  logic [4:0]  r_sync1;
  logic [4:0]  r_sync2;
  logic        r_wr;
  logic        r_uds;
  logic        r_lds;
  logic [22:0] r_addr;
  logic [15:0] r_data;
  logic        w_accept;
  logic        w_tmo;
  logic        w_set_berr;
  logic        w_set_tmo;
  logic        w_bg_s;
  logic        w_bgack_s;
  logic        w_as_s;
  logic        w_dtack_s;
  logic        w_berr_s;

  assign w_bg_s    = r_sync2[4];
  assign w_bgack_s = r_sync2[3];
  assign w_as_s    = r_sync2[2];
  assign w_dtack_s = r_sync2[1];
  assign w_berr_s  = r_sync2[0];
  assign w_tmo     = (r_timer >= TMO_LAST);
  assign w_accept  = (r_state == S_IDLE) && CMD_VALID_IN;

  // Two-flop synchronisers for the asynchronous bus pins.
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {BG_IN, BGACK_IN, AS_IN, DTACK_IN, BERR_IN};
      r_sync2 <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Saturating cycle timer, restarted on every state change.
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN)                   r_timer <= '0;
    else if (w_state_nxt != r_state) r_timer <= '0;
    else if (r_timer != 16'hFFFF)   r_timer <= r_timer + 16'd1;
  end

  // Command capture and response registers; an all-zero lane mask means a word access.
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      r_wr        <= 1'b0;
      r_uds       <= 1'b0;
      r_lds       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      RSP_DATA    <= '0;
      RSP_BERR    <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr        <= CMD_WR_IN;
        r_addr      <= CMD_ADDR_IN;
        r_data      <= CMD_DATA_IN;
        r_uds       <= CMD_UDS_IN | ~(CMD_UDS_IN | CMD_LDS_IN);
        r_lds       <= CMD_LDS_IN | ~(CMD_UDS_IN | CMD_LDS_IN);
        RSP_BERR    <= 1'b0;
        RSP_TIMEOUT <= 1'b0;
      end
      if (w_set_berr) RSP_BERR <= 1'b1;
      if (w_set_tmo)  RSP_TIMEOUT <= 1'b1;
      // DTACK_S lags the pin by two cycles, so DATA_IN has long settled here.
      if (r_state == S_LATCH) RSP_DATA <= DATA_IN;
    end
  end

  // Next-state and bus outputs decoded from the state (strobes lag STROBE by one cycle).
  always_comb begin
    w_state_nxt = r_state;
    w_set_berr  = 1'b0;
    w_set_tmo   = 1'b0;
    CMD_READY   = 1'b0;
    RSP_VALID   = 1'b0;
    BR          = 1'b0;
    BUS_OE      = 1'b0;
    AS_OUT      = 1'b0;
    UDS_OUT     = 1'b0;
    LDS_OUT     = 1'b0;
    case (r_state)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID_IN) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        BR = 1'b1;
        if (w_bg_s && !w_as_s && !w_bgack_s) begin
          w_state_nxt = S_SETUP;
        end else if (w_tmo) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_SETUP: begin
        BUS_OE = 1'b1;
        if (r_timer >= SETUP_LAST) w_state_nxt = S_STROBE;
      end
      S_STROBE: begin
        BUS_OE      = 1'b1;
        w_state_nxt = r_wr ? S_WRDS : S_WAIT;
      end
      S_WRDS: begin
        BUS_OE      = 1'b1;
        AS_OUT      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        BUS_OE  = 1'b1;
        AS_OUT  = 1'b1;
        UDS_OUT = r_uds;
        LDS_OUT = r_lds;
        if (w_berr_s) begin
          w_set_berr  = 1'b1;
          w_state_nxt = S_END;
        end else if (w_dtack_s) begin
          w_state_nxt = r_wr ? S_END : S_LATCH;
        end else if (w_tmo) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = S_END;
        end
      end
      S_LATCH: begin
        BUS_OE      = 1'b1;
        AS_OUT      = 1'b1;
        UDS_OUT     = r_uds;
        LDS_OUT     = r_lds;
        w_state_nxt = S_END;
      end
      S_END: begin
        BUS_OE      = 1'b1;
        w_state_nxt = S_NEG;
      end
      S_NEG: begin
        BUS_OE = 1'b1;
        if (!w_dtack_s && !w_berr_s) begin
          w_state_nxt = S_RELEASE;
        end else if (w_tmo) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: w_state_nxt = S_DONE;
      S_DONE: begin
        RSP_VALID   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    BGACK    = BUS_OE;
    WR_OUT   = BUS_OE & r_wr;
    DATA_OE  = BUS_OE & r_wr;
    ADDR_OUT = BUS_OE ? r_addr : '0;
    DATA_OUT = DATA_OE ? r_data : '0;
  end

endmodule
